stack_row_controller: RTL
=========================

Name: stack_row_controller

Overview:
- Sequences one round of the block-stacker game: slides the active row left/right at the rate set by the level FSM, latches it on the player's drop, and scores overlap against the row below.
- Emits the go / next_signal handshake that advances or resets the level FSM.
- Sits between the button/frame-tick logic and the level FSM. Its row outputs feed the VGA draw path.

Parameters:
- COLS, 7, board width in columns (max 15).
- MAX_LEVEL, 15, final level number; surviving it means a win.
- SPEED_W, 11, width of speed_count.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; one clock clk; reset resetn is synchronous and active-high
- start  in  1  1-cycle pulse; begins or restarts a game
- drop  in  1  1-cycle pulse; player drop button, debounced
- frame_tick  in  1  1-cycle pulse per video frame (60 Hz)
- speed_count  in  SPEED_W  frames per column step, from the level FSM
- num_blocks  in  4  requested row width, from the level FSM
- curr_level  in  6  current level, from the level FSM
- row_mask  out  COLS  active row; bit i set = column i lit
- lvl_go  out  1  go pulse to the level FSM
- next_signal  out  1  pass (1) or fail (0) result to the level FSM
- busy  out  1  high in CHECK / REPORT_GO / REPORT_RES
- game_over  out  1  sticky loss flag
- win  out  1  sticky win flag

Behaviour:
- Reset values:
  - state=IDLE, row_mask=0, lvl_go=0, next_signal=0, busy=0, game_over=0, win=0.
  - Internal: prev_mask=all ones, width=1, pos=0, dir=right, frame_cnt=0.
- States: IDLE, MOVE, CHECK, REPORT_GO, REPORT_RES, DONE.
- IDLE:
  - On start: width = clamp(num_blocks, 1..COLS), where 0 is treated as 1. pos=0, dir=right, frame_cnt=0, prev_mask=all ones, flags cleared. Go to MOVE.
- MOVE:
  - row_mask = ((1<<width)-1) << pos.
  - Each frame_tick increments frame_cnt. When frame_cnt == period-1: clear frame_cnt and step pos by 1 in dir.
  - period = speed_count, with 0 treated as 1.
  - Bounce: if pos+width == COLS while moving right, dir flips and pos decrements on this step; symmetric at pos == 0. pos never leaves 0..COLS-width.
  - width == COLS: pos stays 0 and there is no motion.
  - On drop: go to CHECK. A drop in the same cycle as a step wins; the pre-step row_mask is latched.
- CHECK (1 cycle): ov = row_mask & prev_mask; ovc = popcount(ov).
- REPORT_GO (1 cycle): lvl_go=1.
- REPORT_RES (1 cycle, the cycle after lvl_go):
  - next_signal = (ovc != 0) && (curr_level != MAX_LEVEL).
  - If ovc == 0: game_over=1, go to DONE.
  - Else if curr_level == MAX_LEVEL: win=1, go to DONE.
  - Else: prev_mask=ov, width = min(clamp(num_blocks), ovc), pos=0, dir=right, frame_cnt=0, go to MOVE.
- DONE: row_mask holds ov. Flags stay sticky until start, which re-enters the IDLE start action directly.
- Input handling:
  - drop is ignored outside MOVE.
  - start is ignored while busy. start during MOVE restarts the game.
  - frame_tick outside MOVE is ignored and frame_cnt holds.
- Handshake latency: drop at cycle N gives lvl_go at N+2 and next_signal at N+3. Each is a single-cycle pulse.
- Reset asserted in any state forces the reset values on the next edge; any handshake in flight is aborted.

Optional Feature:
- STACK_SPEEDUP_EN defined: period = max(2, speed_count - 4*(curr_level-1)), saturating with no underflow.
- Undefined: period = speed_count exactly, with 0 treated as 1.

Decomposition:
- Shared package holds: state enum (3-bit), COLS, MAX_LEVEL, SPEED_W, and a popcount function.
- Sub-module stack_frame_divider:
  - Inputs: frame_tick, period, clear, enable.
  - Output: step pulse.
  - Owns frame_cnt.

Test Plan:
- Movement and bounce: speed_count=2, num_blocks=3, COLS=7, start, 20 frame_ticks. Expect row_mask 0x07 -> 0x0E after 2 ticks; reaches 0x70; next step 0x38 (bounce).
- Pass handshake: drop while row_mask=0x07 at level 1. Expect lvl_go exactly 2 cycles after drop, next_signal=1 the following cycle, new width=3, back in MOVE.
- Partial overlap: prev_mask=0x07, drop at 0x0E. Expect ovc=2, next row width 2, row_mask=0x03.
- Miss: prev_mask=0x03, drop at 0x70. Expect next_signal=0 in the REPORT_RES cycle, game_over=1, drop ignored afterwards.
- Win and restart: curr_level=15, overlapping drop. Expect win=1, next_signal=0; start clears win and returns row_mask=0x07.
- Reset mid-handshake: resetn=1 in the lvl_go cycle. Expect all outputs at reset values next edge and no next_signal pulse.

Source files
------------

// File: rtl/stack_row_controller_pkg.sv
// stack_row_controller_pkg: shared board constants, FSM state encoding, and row helper functions
package stack_row_controller_pkg;
  localparam int COLS = 7;
  localparam int MAX_LEVEL = 15;
  localparam int SPEED_W = 11;
  typedef enum logic [2:0] {IDLE, MOVE, CHECK, REPORT_GO, REPORT_RES, DONE} state_t;
  function automatic logic [3:0] popcount(input logic [COLS-1:0] v);
    popcount = '0;
    for (int i = 0; i < COLS; i++) popcount += 4'(v[i]);
  endfunction
  function automatic logic [COLS-1:0] row_of(input logic [3:0] w, input logic [3:0] p);
    row_of = COLS'(((16'd1 << w) - 16'd1) << p);
  endfunction
endpackage

// File: rtl/stack_frame_divider.sv
// stack_frame_divider: emits a step pulse every period frame ticks while enabled (clk, rst, frame_tick, period, clear, enable -> step); owns frame_cnt
module stack_frame_divider
  import stack_row_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [SPEED_W-1:0] period,
  input  logic               clear,
  input  logic               enable,
  output logic               step
);
  logic [SPEED_W-1:0] frame_cnt;
  assign step = enable && frame_tick && (frame_cnt >= period - SPEED_W'(1));
  always_ff @(posedge clk)
    if (rst || clear) frame_cnt <= '0;
    else if (enable && frame_tick) frame_cnt <= step ? '0 : frame_cnt + SPEED_W'(1);
endmodule

// File: rtl/stack_row_controller.sv
// stack_row_controller: one stacker round (slide row, latch on drop, score overlap, go/next_signal to level FSM); in clk resetn(sync active-high) start drop frame_tick speed_count num_blocks curr_level, out row_mask lvl_go next_signal busy game_over win; STACK_SPEEDUP_EN shortens the step period with level
module stack_row_controller
  import stack_row_controller_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               drop,
  input  logic               frame_tick,
  input  logic [SPEED_W-1:0] speed_count,
  input  logic [3:0]         num_blocks,
  input  logic [5:0]         curr_level,
  output logic [COLS-1:0]    row_mask,
  output logic               lvl_go,
  output logic               next_signal,
  output logic               busy,
  output logic               game_over,
  output logic               win
);
  state_t state;
  logic [COLS-1:0] prev_mask, ov;
  logic [3:0] width, pos, ovc, req_w, next_w, next_pos;
  logic dir_left, begin_game, pass, step, hit_edge;
  logic [SPEED_W-1:0] period;
  assign req_w = num_blocks == 4'd0 ? 4'd1 : num_blocks > 4'(COLS) ? 4'(COLS) : num_blocks;
  assign next_w = ovc < req_w ? ovc : req_w;
  assign begin_game = start && (state == IDLE || state == MOVE || state == DONE);
  assign pass = ovc != 4'd0 && curr_level != 6'(MAX_LEVEL);
  assign hit_edge = dir_left ? pos == 4'd0 : {1'b0, pos} + {1'b0, width} == 5'(COLS);
  assign next_pos = (dir_left ^ hit_edge) ? pos - 4'd1 : pos + 4'd1;
`ifdef STACK_SPEEDUP_EN
  logic [SPEED_W+1:0] cut;
  assign cut = curr_level == 6'd0 ? '0 : (SPEED_W+2)'(curr_level - 6'd1) << 2;
  assign period = (SPEED_W+2)'(speed_count) > cut + (SPEED_W+2)'(2) ? SPEED_W'((SPEED_W+2)'(speed_count) - cut) : SPEED_W'(2);
`else
  assign period = speed_count == '0 ? SPEED_W'(1) : speed_count;
`endif
  stack_frame_divider divider (
    .clk(clk),
    .rst(resetn),
    .frame_tick(frame_tick),
    .period(period),
    .clear(begin_game || (state == REPORT_RES && pass)),
    .enable(state == MOVE),
    .step(step)
  );
  always_ff @(posedge clk)
    if (resetn) begin
      state <= IDLE;
      row_mask <= '0;
      lvl_go <= 1'b0;
      next_signal <= 1'b0;
      busy <= 1'b0;
      game_over <= 1'b0;
      win <= 1'b0;
      prev_mask <= '1;
      width <= 4'd1;
      pos <= '0;
      dir_left <= 1'b0;
      ov <= '0;
      ovc <= '0;
    end else begin
      lvl_go <= 1'b0;
      next_signal <= 1'b0;
      if (begin_game) begin
        state <= MOVE;
        width <= req_w;
        pos <= '0;
        dir_left <= 1'b0;
        prev_mask <= '1;
        row_mask <= row_of(req_w, 4'd0);
        game_over <= 1'b0;
        win <= 1'b0;
      end else
        case (state)
          MOVE:
            if (drop) begin
              state <= CHECK;
              busy <= 1'b1;
            end else if (step && width != 4'(COLS)) begin
              pos <= next_pos;
              dir_left <= dir_left ^ hit_edge;
              row_mask <= row_of(width, next_pos);
            end
          CHECK: begin
            ov <= row_mask & prev_mask;
            ovc <= popcount(row_mask & prev_mask);
            lvl_go <= 1'b1;
            state <= REPORT_GO;
          end
          REPORT_GO: begin
            next_signal <= pass;
            state <= REPORT_RES;
          end
          REPORT_RES: begin
            busy <= 1'b0;
            if (pass) begin
              prev_mask <= ov;
              width <= next_w;
              pos <= '0;
              dir_left <= 1'b0;
              row_mask <= row_of(next_w, 4'd0);
              state <= MOVE;
            end else begin
              game_over <= ovc == 4'd0;
              win <= ovc != 4'd0;
              row_mask <= ov;
              state <= DONE;
            end
          end
          default: ;
        endcase
    end
endmodule
